// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between the MCU register block (master) and freq_sweep_ctrl (slave).
// Carries the sweep setup, start/abort pulses and the registered tuning-word outputs.
interface freq_sweep_ctrl_if #(
    parameter int DWELL_W = 24
);
    logic               START;
    logic               STOP;
    logic               MODE;
    logic [31:0]        START_W;
    logic [31:0]        STOP_W;
    logic [31:0]        STEP_W;
    logic [DWELL_W-1:0] DWELL;
    logic [15:0]        FREQH_W;
    logic [15:0]        FREQL_W;
    logic               EN_OUT;
    logic               BUSY;
    logic               DONE;

    modport master (
        output START, STOP, MODE, START_W, STOP_W, STEP_W, DWELL,
        input  FREQH_W, FREQL_W, EN_OUT, BUSY, DONE
    );

    modport slave (
        input  START, STOP, MODE, START_W, STOP_W, STEP_W, DWELL,
        output FREQH_W, FREQL_W, EN_OUT, BUSY, DONE
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps a 32-bit tuning word START_W..STOP_W, D cycles per point.
// Define FREQ_SWEEP_TRI_EN to make continuous mode (MODE=1) a triangle sweep instead of sawtooth.
module freq_sweep_ctrl #(
    parameter int DWELL_W = 24
) (
    input logic              CLK,
    input logic              RST,
    freq_sweep_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        start_q, start_d;
    logic [31:0]        stop_q, stop_d;
    logic [31:0]        step_q, step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] last_q, last_d;
    logic               mode_q, mode_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [32:0]        sum;
    logic [31:0]        inc_word;
`ifdef FREQ_SWEEP_TRI_EN
    logic               down_q, down_d;
    logic [32:0]        diff;
    logic [31:0]        dec_word;
`endif

    // Upward step, saturating at the stop word on overshoot or 32-bit carry.
    assign sum      = {1'b0, word_q} + {1'b0, step_q};
    assign inc_word = (sum[32] || (sum[31:0] >= stop_q)) ? stop_q : sum[31:0];
`ifdef FREQ_SWEEP_TRI_EN
    assign diff     = {1'b0, word_q} - {1'b0, step_q};
    assign dec_word = (diff[32] || (diff[31:0] < start_q)) ? start_q : diff[31:0];
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
        state_d = state_q;
        word_d  = word_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FREQ_SWEEP_TRI_EN
        down_d  = down_q;
`endif
        if (bus.STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
`ifdef FREQ_SWEEP_TRI_EN
            down_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        start_d = bus.START_W;
                        stop_d  = bus.STOP_W;
                        step_d  = (bus.STEP_W == 32'd0) ? 32'd1 : bus.STEP_W;
                        last_d  = (bus.DWELL == '0) ? '0 : bus.DWELL - DWELL_W'(1);
                        mode_d  = bus.MODE;
                        word_d  = (bus.START_W >= bus.STOP_W) ? bus.STOP_W : bus.START_W;
                        cnt_d   = '0;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = DWELL;
`ifdef FREQ_SWEEP_TRI_EN
                        down_d  = 1'b0;
`endif
                    end
                end
                DWELL: begin
                    if (cnt_q != last_q) begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end else begin
                        cnt_d = '0;
`ifdef FREQ_SWEEP_TRI_EN
                        if (mode_q && down_q) begin
                            // Reversal at START_W steps straight up so the endpoint is held once.
                            if (word_q == start_q) begin
                                down_d = 1'b0;
                                word_d = inc_word;
                            end else begin
                                word_d = dec_word;
                            end
                        end else
`endif
                        if (word_q != stop_q) begin
                            word_d = inc_word;
                        end else if (!mode_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
`ifdef FREQ_SWEEP_TRI_EN
                            down_d = 1'b1;
                            word_d = dec_word;
`else
                            word_d = start_q;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            word_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FREQ_SWEEP_TRI_EN
            down_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates make every register see the same pre-edge values.
            state_q <= state_d;
            word_q  <= word_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FREQ_SWEEP_TRI_EN
            down_q  <= down_d;
`endif
        end
    end

    // Both halves come from the same register, so H/L can never be torn.
    assign bus.FREQH_W = word_q[31:16];
    assign bus.FREQL_W = word_q[15:0];
    assign bus.EN_OUT  = en_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: directed scenarios plus randomized sweeps against a
// point-list model (triangle model used when FREQ_SWEEP_TRI_EN is defined).
module tb_freq_sweep_ctrl;

    localparam int DW = 24;

    logic CLK = 1'b0;
    logic RST;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_pts[$];

    always #5 CLK = ~CLK;

    freq_sweep_ctrl_if #(.DWELL_W(DW)) bus ();

    freq_sweep_ctrl #(.DWELL_W(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [31:0] cur_word();
        return {bus.FREQH_W, bus.FREQL_W};
    endfunction

    // One period of presented points: the full list for a single sweep, the repeating unit otherwise.
    task automatic build_points(input logic [31:0] s, input logic [31:0] p,
                                input logic [31:0] st, input logic cont);
        logic [31:0] w;
        logic [32:0] nxt;
        logic [31:0] stp;
        exp_pts.delete();
        stp = (st == 32'd0) ? 32'd1 : st;
        if (s >= p) begin
            exp_pts.push_back(p);
            return;
        end
        w = s;
        exp_pts.push_back(w);
        while (w != p) begin
            nxt = {1'b0, w} + {1'b0, stp};
            w = (nxt >= {1'b0, p}) ? p : nxt[31:0];
            exp_pts.push_back(w);
        end
`ifdef FREQ_SWEEP_TRI_EN
        if (cont) begin
            w = p;
            while ({1'b0, w} > {1'b0, s} + {1'b0, stp}) begin
                w = w - stp;
                exp_pts.push_back(w);
            end
        end
`else
        if (cont) w = p;
`endif
    endtask

    // Start a sweep, check every cycle, then either expect completion or abort with STOP.
    task automatic run_sweep(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                             input logic [DW-1:0] dw, input logic md, input int max_cycles);
        int d, n_cyc;
        logic [31:0] exp_w, held;
        bit finishes;
        d = (dw == '0) ? 1 : int'(dw);
        build_points(s, p, st, md);
        finishes = !md && (max_cycles >= exp_pts.size() * d);
        n_cyc = finishes ? exp_pts.size() * d : max_cycles;
        bus.START_W = s;
        bus.STOP_W  = p;
        bus.STEP_W  = st;
        bus.DWELL   = dw;
        bus.MODE    = md;
        bus.START   = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            exp_w = exp_pts[(c / d) % exp_pts.size()];
            vectors++;
            if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== {exp_w, 3'b110}) begin
                miscompares++;
                $display("FAIL sweep cycle %0d: word=%h busy=%b en=%b done=%b, required word=%h busy=1 en=1 done=0",
                         c, cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE, exp_w);
            end
            // Mid-sweep START and input churn must be ignored.
            bus.START   = ($urandom_range(0, 3) == 0);
            bus.START_W = $urandom;
            bus.STOP_W  = $urandom;
            bus.STEP_W  = $urandom;
            bus.DWELL   = DW'($urandom);
            bus.MODE    = 1'($urandom);
            @(negedge CLK);
        end
        bus.START = 1'b0;
        if (finishes) begin
            vectors++;
            if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== {p, 3'b011}) begin
                miscompares++;
                $display("FAIL done pulse: word=%h busy=%b en=%b done=%b, required word=%h busy=0 en=1 done=1",
                         cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE, p);
            end
            @(negedge CLK);
            vectors++;
            if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== {p, 3'b010}) begin
                miscompares++;
                $display("FAIL after done: word=%h busy=%b en=%b done=%b, required word=%h busy=0 en=1 done=0",
                         cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE, p);
            end
        end else begin
            held = exp_pts[(n_cyc / d) % exp_pts.size()];
            bus.STOP = 1'b1;
            @(negedge CLK);
            bus.STOP = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== {held, 3'b000}) begin
                    miscompares++;
                    $display("FAIL abort hold %0d: word=%h busy=%b en=%b done=%b, required word=%h busy=0 en=0 done=0",
                             k, cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE, held);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        RST         = 1'b1;
        bus.START   = 1'b0;
        bus.STOP    = 1'b0;
        bus.MODE    = 1'b0;
        bus.START_W = 32'h0001_0000;
        bus.STOP_W  = 32'h0009_0000;
        bus.STEP_W  = 32'h0001_0000;
        bus.DWELL   = DW'(3);
        #3;
        vectors++;
        if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset state: word=%h busy=%b en=%b done=%b, required all zero",
                     cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (5) @(negedge CLK);
        vectors++;
        if ({bus.BUSY, bus.EN_OUT} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre-reset run: busy=%b en=%b, required busy=1 en=1", bus.BUSY, bus.EN_OUT);
        end
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        vectors++;
        if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== 35'd0) begin
            miscompares++;
            $display("FAIL async reset: word=%h busy=%b en=%b done=%b, required all zero",
                     cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        run_sweep(32'h0001_0000, 32'h0004_0000, 32'h0001_0000, DW'(3), 1'b0, 1000);
    endtask

    task automatic test_clamp();
        run_sweep(32'h0001_0000, 32'h0004_0000, 32'h0003_0000, DW'(2), 1'b0, 1000);
        run_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, DW'(2), 1'b0, 1000);
    endtask

    task automatic test_degenerate();
        run_sweep(32'd5, 32'd7, 32'd0, DW'(0), 1'b0, 1000);
        run_sweep(32'd9, 32'd4, 32'd1, DW'(2), 1'b0, 1000);
    endtask

    task automatic test_continuous();
        run_sweep(32'h0001_0000, 32'h0003_0000, 32'h0001_0000, DW'(2), 1'b1, 20);
        // Abort in the middle of the return leg, then restart: must begin going up from START_W.
        run_sweep(32'h0001_0000, 32'h0003_0000, 32'h0001_0000, DW'(2), 1'b1, 7);
        run_sweep(32'h0001_0000, 32'h0003_0000, 32'h0001_0000, DW'(2), 1'b1, 16);
    endtask

    task automatic test_stop();
        logic [31:0] held;
        held = cur_word();
        bus.START_W = 32'h1234_0000;
        bus.STOP_W  = 32'h5678_0000;
        bus.STEP_W  = 32'h0001_0000;
        bus.DWELL   = DW'(2);
        bus.MODE    = 1'b0;
        bus.START   = 1'b1;
        bus.STOP    = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        vectors++;
        if ({cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE} !== {held, 3'b000}) begin
            miscompares++;
            $display("FAIL stop beats start: word=%h busy=%b en=%b done=%b, required word=%h busy=0 en=0 done=0",
                     cur_word(), bus.BUSY, bus.EN_OUT, bus.DONE, held);
        end
        @(negedge CLK);
        // Mid-dwell abort on the second point.
        run_sweep(32'h0000_0100, 32'h0000_0900, 32'h0000_0100, DW'(3), 1'b0, 4);
    endtask

    task automatic test_random();
        logic [31:0] s, p, st;
        logic [32:0] span, top;
        logic        md;
        int          d;
        for (int it = 0; it < 30; it++) begin
            md = 1'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 32'hFFF))) : $urandom;
            st = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
            span = (st == 32'd0) ? 33'($urandom_range(0, 5))
                                 : 33'(st) * 33'($urandom_range(0, 6)) + 33'($urandom_range(0, int'(st)));
            top = {1'b0, s} + span;
            p = top[32] ? 32'hFFFF_FFFF : top[31:0];
            if (!md && $urandom_range(0, 4) == 0) p = (s > 32'd100) ? s - 32'($urandom_range(0, 100)) : s;
            if (md) begin
                if (s == 32'hFFFF_FFFF) s = 32'hFFFF_FFFE;
                if (p <= s) p = s + 32'd1;
            end
            d = $urandom_range(0, 3);
            build_points(s, p, st, md);
            run_sweep(s, p, st, DW'(d), md,
                      md ? (exp_pts.size() * (d == 0 ? 1 : d) * 2 + $urandom_range(0, 5)) : 100000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_degenerate();
        test_continuous();
        test_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
